instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the control unit in the RV64 core. Holds the program counter and requests instruction words from instruction memory over a req/ack handshake. Presents each fetched word as im_data, together with a valid flag, to the control/decode logic. Consumes that logic's PCsrc decision and the immediate-generator's branch offset to select the next PC.

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage of the RV64 core. Owns the program counter, fetches
// one 32-bit instruction word at a time from instruction memory over a
// req/ack handshake, and presents it to the control/decode logic until that
// logic retires it. At retire the next PC is chosen from the sequential
// address or the branch target (pc + imm) according to PCsrc.
//
// Ports:
//   clk         core clock, rising edge
//   rst_n       asynchronous active-low reset
//   PCsrc       branch taken, sampled only at retire
//   imm         signed byte offset for the branch target (pc + imm)
//   stall       holds the current instruction in execute, blocks retire
//   im_req      fetch request to instruction memory (registered)
//   im_addr     word address into instruction memory, pc[AW+1:2]
//   im_ack      memory presents valid im_rdata this cycle
//   im_rdata    instruction word from memory
//   im_data     current instruction for the control unit / decoder
//   instr_valid im_data holds a live instruction
//   pc          byte address of the current instruction
//   fetch_err   sticky flag: a misaligned branch target was taken
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter  int W    = 64,
    parameter  int IM_L = 16,
    localparam int AW   = $clog2(IM_L)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PCsrc,
    input  logic [W-1:0]  imm,
    input  logic          stall,
    output logic          im_req,
    output logic [AW-1:0] im_addr,
    input  logic          im_ack,
    input  logic [31:0]   im_rdata,
    output logic [31:0]   im_data,
    output logic          instr_valid,
    output logic [W-1:0]  pc,
    output logic          fetch_err
);

    // RISC-V canonical NOP (addi x0, x0, 0) shown to decode while idle/reset.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t        state_r;
    logic [W-1:0]  pc_r;
    logic [31:0]   im_data_r;
    logic          instr_valid_r;
    logic          im_req_r;
    logic          fetch_err_r;

    logic [W-1:0]  seq_pc_s;
    logic [W-1:0]  target_s;
    logic [W-1:0]  next_pc_s;
    logic          misaligned_s;

    // Next-PC selection: sequential or branch target, both wrapping mod 2^W.
    always_comb begin
        seq_pc_s     = pc_r + W'(3'd4);
        target_s     = pc_r + imm;
        next_pc_s    = seq_pc_s;
        misaligned_s = 1'b0;
        if (PCsrc) begin
            // Targets are forced onto a word boundary; a non-aligned target
            // is still taken but flagged through fetch_err.
            next_pc_s    = {target_s[W-1:2], 2'b00};
            misaligned_s = (target_s[1:0] != 2'b00);
        end else begin
            next_pc_s    = seq_pc_s;
            misaligned_s = 1'b0;
        end
    end

    // Fetch FSM with all outputs registered; im_req never depends on im_ack
    // combinationally, so the memory side sees a clean, stable request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pc_r          <= '0;
            im_data_r     <= NOP_INSTR;
            instr_valid_r <= 1'b0;
            im_req_r      <= 1'b0;
            fetch_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // First edge after reset release starts fetching at pc.
                    state_r  <= FETCH;
                    im_req_r <= 1'b1;
                end
                FETCH: begin
                    if (im_ack) begin
                        im_data_r     <= im_rdata;
                        instr_valid_r <= 1'b1;
                        im_req_r      <= 1'b0;
                        state_r       <= EXEC;
                    end else begin
                        // Unlimited wait: keep requesting the same address.
                        im_req_r      <= 1'b1;
                        state_r       <= FETCH;
                    end
                end
                EXEC: begin
                    // im_ack here is ignored: nothing is captured outside FETCH.
                    if (!stall) begin
                        pc_r          <= next_pc_s;
                        instr_valid_r <= 1'b0;
                        im_req_r      <= 1'b1;
                        state_r       <= FETCH;
                        if (misaligned_s) begin
                            fetch_err_r <= 1'b1;
                        end else begin
                            fetch_err_r <= fetch_err_r;
                        end
                    end else begin
                        state_r       <= EXEC;
                    end
                end
                default: begin
                    // Illegal encoding: fall back to a quiet idle state.
                    state_r       <= IDLE;
                    im_req_r      <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign im_req      = im_req_r;
    assign im_addr     = pc_r[AW+1:2];
    assign im_data     = im_data_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign fetch_err   = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A small memory model answers
// fetches; each accepted fetch pushes the expected {pc, word} onto a
// scoreboard that is popped when instr_valid rises. The PC model applies the
// next-PC rule independently of the design.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int W    = 64;
    localparam int IM_L = 16;
    localparam int AW   = 4;

    logic          clk;
    logic          rst_n;
    logic          PCsrc;
    logic [W-1:0]  imm;
    logic          stall;
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic          im_ack;
    logic [31:0]   im_rdata;
    logic [31:0]   im_data;
    logic          instr_valid;
    logic [W-1:0]  pc;
    logic          fetch_err;

    instr_fetch_unit #(.W(W), .IM_L(IM_L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCsrc       (PCsrc),
        .imm         (imm),
        .stall       (stall),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .im_data     (im_data),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    typedef struct {
        logic [W-1:0] pc;
        logic [31:0]  data;
    } exp_t;

    exp_t         sb[$];
    logic [31:0]  mem [IM_L];
    logic [W-1:0] model_pc;
    logic         model_err;
    logic [31:0]  last_data;
    int           checks;
    int           errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch one instruction: wait for im_req, hold off ack for 'delay' cycles,
    // then ack and check the presented instruction one cycle later.
    task automatic do_fetch(input int delay, input string tag);
        int           waited;
        logic [AW-1:0] exp_addr;
        exp_t         e;
        waited = 0;
        while (im_req !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (im_req !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout got %b want 1", tag, im_req);
            return;
        end
        exp_addr = model_pc[AW+1:2];
        checks++;
        if (im_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s im_addr got %0d want %0d", tag, im_addr, exp_addr);
        end
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            checks++;
            if (im_req !== 1'b1 || im_addr !== exp_addr || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s wait_hold req=%b addr=%0d valid=%b want 1/%0d/0",
                         tag, im_req, im_addr, instr_valid, exp_addr);
            end
        end
        im_ack   = 1'b1;
        im_rdata = mem[exp_addr];
        e.pc     = model_pc;
        e.data   = mem[exp_addr];
        sb.push_back(e);
        @(negedge clk);
        im_ack   = 1'b0;
        im_rdata = $urandom();
        checks++;
        if (instr_valid !== 1'b1 || im_req !== 1'b0) begin
            errors++;
            $display("FAIL %s after_ack valid=%b req=%b want 1/0", tag, instr_valid, im_req);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got 0 entries want 1", tag);
        end else begin
            e = sb.pop_front();
            last_data = e.data;
            if (im_data !== e.data || pc !== e.pc) begin
                errors++;
                $display("FAIL %s instr got data=%h pc=%h want data=%h pc=%h",
                         tag, im_data, pc, e.data, e.pc);
            end
        end
    endtask

    // Hold in EXEC for 'stalls' cycles (with noise on PCsrc/imm/im_ack), then
    // retire with the given branch decision and check the new PC.
    task automatic do_retire(input logic src, input logic [W-1:0] off,
                             input int stalls, input string tag);
        logic [W-1:0] target;
        for (int i = 0; i < stalls; i++) begin
            stall    = 1'b1;
            PCsrc    = i[0];
            imm      = {$urandom(), $urandom()};
            im_ack   = 1'b1;
            im_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            checks++;
            if (pc !== model_pc || im_data !== last_data || instr_valid !== 1'b1 ||
                im_req !== 1'b0) begin
                errors++;
                $display("FAIL %s stall_hold pc=%h data=%h valid=%b req=%b want %h/%h/1/0",
                         tag, pc, im_data, instr_valid, im_req, model_pc, last_data);
            end
        end
        im_ack = 1'b0;
        stall  = 1'b0;
        PCsrc  = src;
        imm    = off;
        target = model_pc + off;
        if (src) begin
            model_pc = {target[W-1:2], 2'b00};
            if (target[1:0] != 2'b00) model_err = 1'b1;
        end else begin
            model_pc = model_pc + 64'd4;
        end
        @(negedge clk);
        PCsrc = 1'b0;
        imm   = '0;
        checks++;
        if (pc !== model_pc || instr_valid !== 1'b0 || im_req !== 1'b1) begin
            errors++;
            $display("FAIL %s retire pc=%h valid=%b req=%b want %h/0/1",
                     tag, pc, instr_valid, im_req, model_pc);
        end
        checks++;
        if (fetch_err !== model_err) begin
            errors++;
            $display("FAIL %s fetch_err got %b want %b", tag, fetch_err, model_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 64'd0 || im_req !== 1'b0 || instr_valid !== 1'b0 ||
            im_data !== 32'h0000_0013 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h req=%b valid=%b data=%h err=%b want 0/0/0/00000013/0",
                     pc, im_req, instr_valid, im_data, fetch_err);
        end
        rst_n = 1'b1;
        model_pc  = '0;
        model_err = 1'b0;
        #1;
        checks++;
        if (im_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold req=%b valid=%b want 0/0", im_req, instr_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_sequential();
        do_fetch(0, "seq0"); do_retire(1'b0, 64'd0, 0, "seq0");
        do_fetch(0, "seq1"); do_retire(1'b0, 64'd0, 0, "seq1");
    endtask

    task automatic test_ack_delay();
        do_fetch(3, "delay_pc8"); do_retire(1'b0, 64'd0, 0, "delay_pc8");
    endtask

    task automatic test_stall();
        do_fetch(0, "stall_pcC"); do_retire(1'b0, 64'd0, 5, "stall_pcC");
    endtask

    task automatic test_branch();
        do_fetch(0, "br_back");  do_retire(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 0, "br_back");
        do_fetch(0, "br_fwd");   do_retire(1'b1, 64'd8, 0, "br_fwd");
        do_fetch(0, "br_not");   do_retire(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 0, "br_not");
    endtask

    task automatic test_wrap_and_err();
        do_fetch(0, "to_3C");    do_retire(1'b1, 64'h28, 0, "to_3C");
        do_fetch(0, "at_3C");    do_retire(1'b0, 64'd0, 0, "at_3C");
        do_fetch(0, "at_40");    do_retire(1'b1, 64'd6, 0, "misalign");
        do_fetch(0, "at_44");    do_retire(1'b0, 64'd0, 0, "err_sticky");
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge clk);
        checks++;
        if (im_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_fetch_req got %b want 1", im_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 64'd0 || im_req !== 1'b0 || instr_valid !== 1'b0 ||
            im_data !== 32'h0000_0013 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pc=%h req=%b valid=%b data=%h err=%b want 0/0/0/00000013/0",
                     pc, im_req, instr_valid, im_data, fetch_err);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        model_pc  = '0;
        model_err = 1'b0;
        sb.delete();
        do_fetch(0, "restart");
    endtask

    task automatic test_pc_64bit_wrap();
        do_retire(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, "to_top");
        do_fetch(0, "at_top");   do_retire(1'b0, 64'd0, 0, "wrap64");
        do_fetch(0, "after_wrap");
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        PCsrc    = 1'b0;
        imm      = '0;
        stall    = 1'b0;
        im_ack   = 1'b0;
        im_rdata = '0;
        model_pc  = '0;
        model_err = 1'b0;
        last_data = 32'h0000_0013;
        for (int i = 0; i < IM_L; i++) begin
            mem[i] = 32'hC0DE_0000 | (i * 32'h0001_0101);
        end
        test_reset();
        test_sequential();
        test_ack_delay();
        test_stall();
        test_branch();
        test_wrap_and_err();
        test_reset_mid_fetch();
        test_pc_64bit_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
